sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single external SRAM port between two requesters: the read stream that fills the input/label buffers (x/t load) and a write stream that stores results or weights back to SRAM. Arbitrates per word, sequences the SRAM control strobes (cs_n, oe_n, we_n, data_output_en) with guaranteed bus turnaround, and returns read data with fixed latency. Sits between the requesters and the SRAM pad drivers.

## Interface
- ADDR_W, 17, SRAM word address width
- DATA_W, 16, SRAM data width
- MAX_BURST, 8, max consecutive read grants while a write is pending (≥1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- rd_req  in  1  read request, held until granted
- rd_addr  in  ADDR_W  read address, valid while rd_req
- rd_gnt  out  1  combinational; read accepted this cycle
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle pulse, rd_data valid
- wr_req  in  1  write request, held until granted
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_gnt  out  1  combinational; write accepted this cycle
- sram_dq_in  in  DATA_W  data from SRAM pads
- sram_dq_out  out  DATA_W  data to SRAM pads
- sram_addr  out  ADDR_W  SRAM address
- sram_data_output_en  out  1  pad output enable (1 = drive dq)
- sram_cs_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes
- busy  out  1  state != IDLE

## Operation
- States: IDLE, READ, W1 (setup), W2 (strobe), W3 (hold).
- Acceptance only in IDLE or READ; W1–W3 assert no grant.
- Selection when accepting: only one req → it wins. Both → read wins if last owner was write, or last owner was read and burst_cnt < MAX_BURST; else write wins.
- burst_cnt: increments on each read accept, cleared on write accept; saturates at MAX_BURST.
- Read accept: sram_addr<=rd_addr, cs_n<=0, oe_n<=0, den<=0, state<=READ. Next edge: rd_data<=sram_dq_in, rd_valid<=1.
- READ with no accept: state<=IDLE, cs_n<=1, oe_n<=1.
- Write accept: sram_addr<=wr_addr, sram_dq_out<=wr_data, cs_n<=0, oe_n<=1, den<=0, state<=W1.
- W1→W2: den<=1, we_n<=0. W2→W3: we_n<=1, den stays 1. W3→IDLE: den<=0, cs_n<=1.
- Invariant: den=1 and oe_n=0 never in same cycle; we_n low exactly one cycle per write; addr/data stable W1–W3.
- Reset (async, any state): sram_addr=0, sram_dq_out=0, den=0, cs_n=1, oe_n=1, we_n=1, rd_data=0, rd_valid=0, busy=0, burst_cnt=0, last owner=write, state=IDLE. A write interrupted by reset is abandoned. Grants are 0 while reset is high.

## Timing
- Read: rd_gnt in cycle N → addr/oe_n on pins after edge N → rd_valid/rd_data after edge N+1 (latency 2 edges from grant).
- Read throughput: 1 word/cycle, back-to-back grants in READ; rd_valid stream contiguous.
- Write: 3 cycles on bus (W1–W3), then 1 IDLE cycle before any next grant. Throughput: 1 write per 4 cycles.
- Read→write: write accepted in READ; final read's rd_valid appears on the edge entering W1; oe_n rises at that edge; den rises one cycle later.
- Write→read: through IDLE; den falls one edge before oe_n may fall.
- rd_valid/rd_data stays correct regardless of following state.

## Test plan
- Reset: assert mid-run → all outputs at reset values immediately; no grants until release.
- Single read addr 0x00010, SRAM model returns 0xABCD → rd_gnt same cycle; sram_addr=0x00010, oe_n=0 next cycle; rd_valid=1, rd_data=0xABCD one cycle later; then IDLE, cs_n=1.
- Stream 10 reads 0x00100–0x00109 → 10 consecutive rd_gnt, 10 contiguous rd_valid with matching data, latency 2.
- Single write 0x1F000/0x1234 → W1/W2/W3 sequence; we_n low exactly 1 cycle; den high 2 cycles; oe_n=1 throughout; model holds 0x1234 at 0x1F000.
- rd_req and wr_req held high, MAX_BURST=8 → repeating 8 reads, 1 write; checker: no cycle with den=1 and oe_n=0; all data correct.
- Async reset asserted in W2 → we_n=1 and den=0 without waiting for clk; busy=0; after release, next rd_req granted from IDLE.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM pad bundle for sram_arbiter.
// The slave modport is the arbiter side; master is the requesters plus the pads.
interface sram_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;

    logic [DATA_W-1:0] sram_dq_in;
    logic [DATA_W-1:0] sram_dq_out;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_data_output_en;
    logic              sram_cs_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              busy;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_dq_in,
        output rd_gnt, rd_data, rd_valid, wr_gnt,
        output sram_dq_out, sram_addr, sram_data_output_en,
        output sram_cs_n, sram_oe_n, sram_we_n, busy
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_dq_in,
        input  rd_gnt, rd_data, rd_valid, wr_gnt,
        input  sram_dq_out, sram_addr, sram_data_output_en,
        input  sram_cs_n, sram_oe_n, sram_we_n, busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// Per-word arbiter sharing one SRAM port between a read stream and a write stream.
// Reads pipeline one word per cycle; writes take a setup/strobe/hold sequence.
module sram_arbiter #(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic           clk,
    input  logic           reset,
    sram_arbiter_if.slave  bus
);
    localparam int              BW      = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   MAX_CNT = BW'(MAX_BURST);

    typedef enum logic [2:0] {IDLE, READ, W1, W2, W3} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dq_out_q, dq_out_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              den_q, den_d;
    logic              cs_n_q, cs_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              last_wr_q, last_wr_d;

    logic can_accept;
    logic read_wins;
    logic rd_gnt;
    logic wr_gnt;

    // Grants are combinational and forced low while reset is asserted.
    always_comb begin
        can_accept = ((state_q == IDLE) || (state_q == READ)) && !reset;
        read_wins  = bus.rd_req && (!bus.wr_req || last_wr_q || (burst_q < MAX_CNT));
        rd_gnt     = can_accept && read_wins;
        wr_gnt     = can_accept && bus.wr_req && !read_wins;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dq_out_d   = dq_out_q;
        den_d      = den_q;
        cs_n_d     = cs_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        burst_d    = burst_q;
        last_wr_d  = last_wr_q;
        // Being in READ means the previous edge launched a read address.
        rd_valid_d = (state_q == READ);
        rd_data_d  = (state_q == READ) ? bus.sram_dq_in : rd_data_q;

        case (state_q)
            IDLE, READ: begin
                if (rd_gnt) begin
                    state_d   = READ;
                    addr_d    = bus.rd_addr;
                    cs_n_d    = 1'b0;
                    oe_n_d    = 1'b0;
                    den_d     = 1'b0;
                    last_wr_d = 1'b0;
                    burst_d   = (burst_q == MAX_CNT) ? burst_q : burst_q + 1'b1;
                end else if (wr_gnt) begin
                    state_d   = W1;
                    addr_d    = bus.wr_addr;
                    dq_out_d  = bus.wr_data;
                    cs_n_d    = 1'b0;
                    oe_n_d    = 1'b1;
                    den_d     = 1'b0;
                    last_wr_d = 1'b1;
                    burst_d   = '0;
                end else begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                end
            end
            W1: begin
                state_d = W2;
                den_d   = 1'b1;
                we_n_d  = 1'b0;
            end
            W2: begin
                state_d = W3;
                we_n_d  = 1'b1;
            end
            W3: begin
                state_d = IDLE;
                den_d   = 1'b0;
                cs_n_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                den_d   = 1'b0;
                cs_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            dq_out_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            den_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            burst_q    <= '0;
            last_wr_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dq_out_q   <= dq_out_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            den_q      <= den_d;
            cs_n_q     <= cs_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            burst_q    <= burst_d;
            last_wr_q  <= last_wr_d;
        end
    end

    assign bus.rd_gnt              = rd_gnt;
    assign bus.wr_gnt              = wr_gnt;
    assign bus.rd_data             = rd_data_q;
    assign bus.rd_valid            = rd_valid_q;
    assign bus.sram_addr           = addr_q;
    assign bus.sram_dq_out         = dq_out_q;
    assign bus.sram_data_output_en = den_q;
    assign bus.sram_cs_n           = cs_n_q;
    assign bus.sram_oe_n           = oe_n_q;
    assign bus.sram_we_n           = we_n_q;
    assign bus.busy                = (state_q != IDLE);
endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised and directed bench for sram_arbiter: an SRAM model on the pads and a
// cycle schedule model derived from the arbitration and timing rules.
module tb_sram_arbiter;
    localparam int MAX_BURST = 8;

    logic clk;
    logic reset;

    sram_arbiter_if #(.ADDR_W(17), .DATA_W(16)) bus ();

    sram_arbiter #(.ADDR_W(17), .DATA_W(16), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pad-side memory and the reference memory the model predicts from.
    logic [15:0] sram_mem [bit [16:0]];
    logic [15:0] ref_mem  [bit [16:0]];

    function automatic logic [15:0] fill(input bit [16:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] sram_rd(input bit [16:0] a);
        return sram_mem.exists(a) ? sram_mem[a] : fill(a);
    endfunction

    function automatic logic [15:0] ref_rd(input bit [16:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    // SRAM model: write during the strobe cycle, present read data while oe_n is low.
    initial begin : sram_model
        bus.sram_dq_in = 16'hDEAD;
        forever begin
            @(negedge clk);
            if (!bus.sram_cs_n && !bus.sram_we_n && bus.sram_data_output_en)
                sram_mem[bus.sram_addr] = bus.sram_dq_out;
            bus.sram_dq_in = (!bus.sram_cs_n && !bus.sram_oe_n) ? sram_rd(bus.sram_addr) : 16'hDEAD;
        end
    end

    // Per-cycle occupancy of the SRAM port: 0 idle, 1 read address, 2..4 write setup/strobe/hold.
    int          kind_s [8];
    logic [16:0] addr_s [8];
    logic [15:0] data_s [8];
    bit          rv_s   [8];
    logic [15:0] rvd_s  [8];
    bit          m_last_wr;
    int          m_burst;

    function automatic logic [4:0] pins_for(input int kind);
        case (kind)
            1:       return 5'b00011;
            2:       return 5'b01011;
            3:       return 5'b01101;
            4:       return 5'b01111;
            default: return 5'b11010;
        endcase
    endfunction

    initial begin : compare
        int  k;
        int  s;
        bit  can;
        bit  pr;
        bit  pw;
        k = 0;
        m_last_wr = 1'b1;
        m_burst = 0;
        for (int i = 0; i < 8; i++) begin kind_s[i] = 0; rv_s[i] = 1'b0; end
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int i = 0; i < 8; i++) begin kind_s[i] = 0; rv_s[i] = 1'b0; end
                m_last_wr = 1'b1;
                m_burst = 0;
            end else begin
                s = k % 8;
                check("pins{cs_n,oe_n,den,we_n,busy}",
                      {bus.sram_cs_n, bus.sram_oe_n, bus.sram_data_output_en, bus.sram_we_n, bus.busy},
                      pins_for(kind_s[s]));
                if (kind_s[s] != 0) check("sram_addr", bus.sram_addr, addr_s[s]);
                if (kind_s[s] >= 2) check("sram_dq_out", bus.sram_dq_out, data_s[s]);
                check("den_with_oe_low", bus.sram_data_output_en && !bus.sram_oe_n, 1'b0);
                check("rd_valid", bus.rd_valid, rv_s[s]);
                if (rv_s[s]) check("rd_data", bus.rd_data, rvd_s[s]);

                can = (kind_s[s] <= 1);
                pr  = can && bus.rd_req && (!bus.wr_req || m_last_wr || (m_burst < MAX_BURST));
                pw  = can && bus.wr_req && !pr;
                check("rd_gnt", bus.rd_gnt, pr);
                check("wr_gnt", bus.wr_gnt, pw);

                kind_s[s] = 0;
                rv_s[s]   = 1'b0;
                if (pr) begin
                    kind_s[(k + 1) % 8] = 1;
                    addr_s[(k + 1) % 8] = bus.rd_addr;
                    rv_s[(k + 2) % 8]   = 1'b1;
                    rvd_s[(k + 2) % 8]  = ref_rd(bus.rd_addr);
                    m_last_wr = 1'b0;
                    if (m_burst < MAX_BURST) m_burst++;
                end
                if (pw) begin
                    for (int j = 1; j <= 3; j++) begin
                        kind_s[(k + j) % 8] = j + 1;
                        addr_s[(k + j) % 8] = bus.wr_addr;
                        data_s[(k + j) % 8] = bus.wr_data;
                    end
                    ref_mem[bus.wr_addr] = bus.wr_data;
                    m_last_wr = 1'b1;
                    m_burst = 0;
                end
            end
            k++;
        end
    end

    bit gr;
    bit gw;

    task automatic step();
        @(negedge clk);
        gr = bus.rd_gnt;
        gw = bus.wr_gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        repeat (n) step();
    endtask

    initial begin : stimulus
        int rd_run;
        int wr_seen;
        int we_lo;
        int den_hi;
        int oe_bad;
        int t;

        sram_mem[17'h00010] = 16'hABCD;
        ref_mem[17'h00010]  = 16'hABCD;
        reset       = 1'b1;
        bus.rd_req  = 1'b1;
        bus.rd_addr = 17'h00123;
        bus.wr_req  = 1'b1;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        // Reset values, with both requests raised to show grants stay low.
        @(negedge clk);
        check("reset_pins", {bus.sram_cs_n, bus.sram_oe_n, bus.sram_data_output_en, bus.sram_we_n, bus.busy}, 5'b11010);
        check("reset_addr_dq", {bus.sram_addr, bus.sram_dq_out}, 33'h0);
        check("reset_rd", {bus.rd_valid, bus.rd_data}, 17'h0);
        check("reset_gnts", {bus.rd_gnt, bus.wr_gnt}, 2'b00);
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        idle(2);

        // Single read of 0x00010.
        bus.rd_req  = 1'b1;
        bus.rd_addr = 17'h00010;
        @(negedge clk);
        check("single_rd_gnt", bus.rd_gnt, 1'b1);
        @(posedge clk);
        #1 bus.rd_req = 1'b0;
        @(negedge clk);
        check("single_rd_addr", bus.sram_addr, 17'h00010);
        check("single_rd_oe_n", bus.sram_oe_n, 1'b0);
        @(negedge clk);
        check("single_rd_valid", bus.rd_valid, 1'b1);
        check("single_rd_data", bus.rd_data, 16'hABCD);
        check("single_rd_cs_n_after", bus.sram_cs_n, 1'b1);
        @(posedge clk);
        #1;
        idle(2);

        // Stream of 10 reads, each must be granted immediately.
        for (int i = 0; i < 10; i++) begin
            bus.rd_req  = 1'b1;
            bus.rd_addr = 17'h00100 + 17'(i);
            step();
            check("stream_gnt", gr, 1'b1);
        end
        idle(4);

        // Single write 0x1F000 <- 0x1234.
        bus.wr_req  = 1'b1;
        bus.wr_addr = 17'h1F000;
        bus.wr_data = 16'h1234;
        @(negedge clk);
        check("single_wr_gnt", bus.wr_gnt, 1'b1);
        @(posedge clk);
        #1 bus.wr_req = 1'b0;
        we_lo = 0; den_hi = 0; oe_bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (!bus.sram_we_n) we_lo++;
            if (bus.sram_data_output_en) den_hi++;
            if (!bus.sram_oe_n) oe_bad++;
        end
        check("wr_we_n_low_cycles", we_lo, 1);
        check("wr_den_high_cycles", den_hi, 2);
        check("wr_oe_n_low_cycles", oe_bad, 0);
        @(posedge clk);
        #1;
        idle(2);
        check("wr_mem_content", sram_rd(17'h1F000), 16'h1234);

        // Both requests held: after the first write, each write follows exactly MAX_BURST reads.
        bus.rd_req  = 1'b1;
        bus.rd_addr = 17'($urandom_range(0, 31));
        bus.wr_req  = 1'b1;
        bus.wr_addr = 17'($urandom_range(0, 31));
        bus.wr_data = 16'($urandom);
        rd_run = 0;
        wr_seen = 0;
        repeat (90) begin
            step();
            if (gr) begin
                rd_run++;
                bus.rd_addr = 17'($urandom_range(0, 31));
            end
            if (gw) begin
                if (wr_seen >= 1) check("burst_run_len", rd_run, MAX_BURST);
                wr_seen++;
                rd_run = 0;
                bus.wr_addr = 17'($urandom_range(0, 31));
                bus.wr_data = 16'($urandom);
            end
        end
        check("burst_write_count_ge6", (wr_seen >= 6), 1'b1);
        idle(4);

        // Random traffic over a small address window so reads hit earlier writes.
        repeat (400) begin
            step();
            if (gr || !bus.rd_req) begin
                bus.rd_req  = ($urandom_range(0, 99) < 60);
                bus.rd_addr = 17'($urandom_range(0, 31));
            end
            if (gw || !bus.wr_req) begin
                bus.wr_req  = ($urandom_range(0, 99) < 35);
                bus.wr_addr = 17'($urandom_range(0, 31));
                bus.wr_data = 16'($urandom);
            end
        end
        idle(4);

        // Reset asserted between edges while the write strobe is low.
        bus.wr_req  = 1'b1;
        bus.wr_addr = 17'h00005;
        bus.wr_data = 16'hBEEF;
        step();
        check("w2_test_wr_gnt", gw, 1'b1);
        bus.wr_req = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.sram_we_n !== 1'b0 && t < 10);
        check("w2_reached", (t < 10), 1'b1);
        #2 reset = 1'b1;
        bus.rd_req  = 1'b1;
        bus.rd_addr = 17'h00007;
        #1;
        check("async_rst_we_n", bus.sram_we_n, 1'b1);
        check("async_rst_den", bus.sram_data_output_en, 1'b0);
        check("async_rst_busy", bus.busy, 1'b0);
        check("async_rst_cs_oe", {bus.sram_cs_n, bus.sram_oe_n}, 2'b11);
        check("async_rst_rd_gnt", bus.rd_gnt, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("gnt_after_reset", bus.rd_gnt, 1'b1);
        @(posedge clk);
        #1 bus.rd_req = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
